// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter and related blocks.
package uart_pkg;

    // Arbiter FSM encoding, kept as plain constants for compatibility with older tools
    localparam logic [1:0] ARB       = 2'b00;
    localparam logic [1:0] WAIT_DONE = 2'b01;
    localparam logic [1:0] GAP       = 2'b10;

    // 115200 baud from a 1.2 GHz-class reference is not assumed; this is the board default
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    // Start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate the request vector so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back. Purely combinational.
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any_valid,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    assign valid_dbl = {valid, valid};
    assign any_valid = |valid;

    // Lowest set bit of the rotated vector, mapped back to an absolute index
    always_comb begin
        rotated = valid_dbl[ptr +: NUM_REQ];
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte sources with round-robin fairness,
// a post-frame idle gap and a watchdog on the transmitter's done signal.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = (FRAME_BITS + 1) * CLKS_PER_BIT + 16
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_L,
    input  logic [NUM_REQ-1:0]         i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Req_Ready,
    output logic [NUM_REQ-1:0]         o_Req_Done,
    output logic                       o_TX_DV,
    output logic [7:0]                 o_TX_Byte,
    input  logic                       i_TX_Active,
    input  logic                       i_TX_Done,
    output logic                       o_Busy,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
    output logic                       o_Timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CLKS);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [1:0]       DONE_NEXT = (GAP_CLKS > 0) ? GAP : ARB;

    logic [1:0]         state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [WD_W-1:0]    wd_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;

    logic               any_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] own_onehot;
    logic [7:0]         win_byte;
    logic               timeout_hit;

    // TX_Active is only of interest to simulation checks; the frame length
    // is fixed by the transmitter, so CLKS_PER_BIT only feeds the watchdog default.
    logic unused_sig;
    assign unused_sig = i_TX_Active | (CLKS_PER_BIT < 1);

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid     (i_Req_Valid),
        .ptr       (ptr_reg),
        .any_valid (any_valid),
        .winner    (win_idx)
    );

    // One-hot decode of the winner (for Ready) and of the owner (for Done)
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        assign own_onehot[gi] = (o_Grant_Id == IDX_W'(gi));
    end

    assign win_byte    = i_Req_Byte[{win_idx, 3'b000} +: 8];
    assign ptr_next    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    assign timeout_hit = (wd_cnt_reg == WD_LAST);

    // Arbiter FSM with registered outputs; pulses default low every cycle.
    // o_Grant_Id doubles as the latched owner of the frame in flight.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg   <= ARB;
            ptr_reg     <= '0;
            wd_cnt_reg  <= '0;
            gap_cnt_reg <= '0;
            o_Req_Ready <= '0;
            o_Req_Done  <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Busy      <= 1'b0;
            o_Grant_Id  <= '0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Req_Ready <= '0;
            o_Req_Done  <= '0;
            o_TX_DV     <= 1'b0;
            o_Timeout   <= 1'b0;
            case (state_reg)
                ARB: begin
                    if (any_valid) begin
                        o_Req_Ready <= win_onehot;
                        o_TX_DV     <= 1'b1;
                        o_TX_Byte   <= win_byte;
                        o_Busy      <= 1'b1;
                        o_Grant_Id  <= win_idx;
                        ptr_reg     <= ptr_next;
                        wd_cnt_reg  <= '0;
                        state_reg   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (wd_cnt_reg != WD_MAX) begin
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    end
                    // Done has priority over a watchdog expiry in the same cycle
                    if (i_TX_Done) begin
                        o_Req_Done  <= own_onehot;
                        o_Busy      <= 1'b0;
                        gap_cnt_reg <= '0;
                        state_reg   <= DONE_NEXT;
                    end else if (timeout_hit) begin
                        o_Timeout   <= 1'b1;
                        o_Busy      <= 1'b0;
                        gap_cnt_reg <= '0;
                        state_reg   <= DONE_NEXT;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ARB;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-plus-random bench for uart_tx_arbiter with a behavioural transmitter.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int TO  = 50;

    logic        clk;
    logic        rst_n;
    logic        tx_dead;

    // Main instance (no gap)
    logic [3:0]  a_valid;
    logic [31:0] a_bytes;
    logic [3:0]  a_ready, a_done;
    logic        a_dv, a_active, a_txdone, a_busy, a_to;
    logic [7:0]  a_byte;
    logic [1:0]  a_gid;
    int          a_bitcnt;

    // Gap instance
    logic [3:0]  g_valid;
    logic [31:0] g_bytes;
    logic [3:0]  g_ready, g_done;
    logic        g_dv, g_active, g_txdone, g_busy, g_to;
    logic [7:0]  g_byte;
    logic [1:0]  g_gid;
    int          g_bitcnt;

    int errors = 0;
    int checks = 0;

    // Reference-model state: round-robin pointer and per-requester byte queues
    int         m_ptr;
    logic [7:0] q [4][$];

    uart_tx_arbiter #(
        .NUM_REQ(N), .CLKS_PER_BIT(CPB), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)
    ) dut (
        .i_Clock(clk), .i_Rst_L(rst_n),
        .i_Req_Valid(a_valid), .i_Req_Byte(a_bytes),
        .o_Req_Ready(a_ready), .o_Req_Done(a_done),
        .o_TX_DV(a_dv), .o_TX_Byte(a_byte),
        .i_TX_Active(a_active), .i_TX_Done(a_txdone),
        .o_Busy(a_busy), .o_Grant_Id(a_gid), .o_Timeout(a_to)
    );

    uart_tx_arbiter #(
        .NUM_REQ(N), .CLKS_PER_BIT(CPB), .GAP_CLKS(8), .TIMEOUT_CLKS(TO)
    ) dut_g (
        .i_Clock(clk), .i_Rst_L(rst_n),
        .i_Req_Valid(g_valid), .i_Req_Byte(g_bytes),
        .o_Req_Ready(g_ready), .o_Req_Done(g_done),
        .o_TX_DV(g_dv), .o_TX_Byte(g_byte),
        .i_TX_Active(g_active), .i_TX_Done(g_txdone),
        .o_Busy(g_busy), .o_Grant_Id(g_gid), .o_Timeout(g_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural transmitter: busy for a full frame after DV, then a one-cycle done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_active <= 1'b0;
            a_txdone <= 1'b0;
            a_bitcnt <= 0;
        end else begin
            a_txdone <= 1'b0;
            if (a_active) begin
                if (a_bitcnt == 10 * CPB - 1) begin
                    a_active <= 1'b0;
                    a_txdone <= !tx_dead;
                end else begin
                    a_bitcnt <= a_bitcnt + 1;
                end
            end else if (a_dv) begin
                a_active <= 1'b1;
                a_bitcnt <= 0;
            end
        end
    end

    // Short stub transmitter for the gap instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_active <= 1'b0;
            g_txdone <= 1'b0;
            g_bitcnt <= 0;
        end else begin
            g_txdone <= 1'b0;
            if (g_active) begin
                if (g_bitcnt == 5) begin
                    g_active <= 1'b0;
                    g_txdone <= 1'b1;
                end else begin
                    g_bitcnt <= g_bitcnt + 1;
                end
            end else if (g_dv) begin
                g_active <= 1'b1;
                g_bitcnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester with a queued byte, scanning upward from the pointer
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            a_valid[k]       = (q[k].size() > 0);
            a_bytes[8*k +: 8] = (q[k].size() > 0) ? q[k][0] : 8'h00;
        end
    endtask

    task automatic wait_grant(output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
            if (clks == 1) chk("done_one_cycle", a_done, 0);
        end while (a_ready == 0 && clks < 200);
        chk("grant_seen", (a_ready != 0), 1);
    endtask

    task automatic wait_end(output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
            if (clks == 1) begin
                chk("ready_one_cycle", a_ready, 0);
                chk("dv_one_cycle", a_dv, 0);
            end
        end while (a_done == 0 && a_to == 0 && clks < 300);
    endtask

    task automatic grant_step(output int w, output logic [7:0] b);
        int clks;
        w = pick(a_valid, m_ptr);
        b = q[w][0];
        wait_grant(clks);
        chk("accept_latency", clks, 1);
        chk("ready_vec", a_ready, 32'(1) << w);
        chk("tx_dv", a_dv, 1);
        chk("tx_byte", a_byte, b);
        chk("grant_id", a_gid, w);
        chk("busy_high", a_busy, 1);
        m_ptr = (w + 1) % N;
        void'(q[w].pop_front());
        refresh();
    endtask

    task automatic serve_one(output int w);
        int clks;
        logic [7:0] b;
        grant_step(w, b);
        wait_end(clks);
        chk("done_vec", a_done, 32'(1) << w);
        chk("timeout_low", a_to, 0);
        chk("busy_low", a_busy, 0);
        chk("byte_hold", a_byte, b);
        $display("grant id=%0d byte=%02h done after %0d clks", w, b, clks);
    endtask

    initial begin
        int w, clks;
        logic [7:0] b;
        int fair [6];
        rst_n   = 1'b0;
        tx_dead = 1'b0;
        m_ptr   = 0;
        a_valid = '0;
        a_bytes = '0;
        g_valid = '0;
        g_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", a_ready, 0);
        chk("rst_dv", a_dv, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_byte", a_byte, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_g_busy", g_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single requester 2, byte A5
        q[2].push_back(8'hA5);
        refresh();
        serve_one(w);

        // 2: fresh reset, all four valid -> 0,1,2,3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int k = 0; k < N; k++) q[k].push_back(8'((k + 1) * 8'h11));
        refresh();
        for (int k = 0; k < N; k++) begin
            serve_one(w);
            chk("order_all4", w, k);
        end

        // 3: fairness between 0 and 3
        for (int k = 0; k < 3; k++) begin
            q[0].push_back(8'($urandom));
            q[3].push_back(8'($urandom));
        end
        refresh();
        for (int k = 0; k < 6; k++) begin
            serve_one(w);
            fair[k] = w;
            chk("fair_order", fair[k], (k % 2 == 0) ? 0 : 3);
        end

        // Random traffic checked against the queue model
        for (int it = 0; it < 16; it++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < N; k++) cnt += q[k].size();
            if (cnt == 0 || $urandom_range(0, 1) == 1) begin
                int r;
                r = $urandom_range(0, N - 1);
                q[r].push_back(8'($urandom));
                if ($urandom_range(0, 1) == 1) q[$urandom_range(0, N - 1)].push_back(8'($urandom));
                refresh();
            end
            serve_one(w);
        end
        while (a_valid != 0) serve_one(w);

        // 4: transmitter never reports done -> watchdog, then next requester served
        tx_dead = 1'b1;
        q[1].push_back(8'h5A);
        q[2].push_back(8'h6B);
        refresh();
        grant_step(w, b);
        wait_end(clks);
        tx_dead = 1'b0;
        chk("timeout_clks", clks, TO);
        chk("timeout_pulse", a_to, 1);
        chk("timeout_no_done", a_done, 0);
        chk("timeout_busy_low", a_busy, 0);
        $display("timeout id=%0d after %0d clks", w, clks);
        serve_one(w);

        // 5: reset in the middle of a data bit
        q[2].push_back(8'hC3);
        refresh();
        grant_step(w, b);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", a_ready, 0);
        chk("midrst_done", a_done, 0);
        chk("midrst_dv", a_dv, 0);
        chk("midrst_byte", a_byte, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_gid", a_gid, 0);
        chk("midrst_to", a_to, 0);
        m_ptr = 0;
        q[1].push_back(8'h96);
        q[3].push_back(8'h69);
        refresh();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_no_done", a_done, 0);
        end
        rst_n = 1'b1;
        serve_one(w);
        chk("post_rst_first", w, 1);
        serve_one(w);
        $display("reset recovery id=%0d", w);

        // 6: gap instance, requester 1 always valid
        g_valid = 4'b0010;
        g_bytes = 32'h0000_7E00;
        clks = 0;
        while (g_done == 0 && clks < 200) begin
            @(negedge clk);
            clks++;
        end
        chk("gap_first_done", g_done, 4'b0010);
        for (int f = 0; f < 2; f++) begin
            clks = 0;
            do begin
                @(negedge clk);
                clks++;
            end while (g_ready == 0 && clks < 100);
            chk("gap_done_to_ready", clks, 9);
            chk("gap_ready_vec", g_ready, 4'b0010);
            chk("gap_byte", g_byte, 8'h7E);
            $display("gap frame %0d: next ready %0d clks after done", f, clks);
            clks = 0;
            do begin
                @(negedge clk);
                clks++;
            end while (g_done == 0 && clks < 100);
            chk("gap_done_vec", g_done, 4'b0010);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
